// File: rtl/ct_pmp_chk_arb_if.sv
// Bundle between the PA-check requesters, the shared ct_pmp_acc port, and the arbiter.
// The arbiter uses the slave modport. The requesters/accessor side uses the master modport.
interface ct_pmp_chk_arb_if #(
    parameter int NUM_REQ   = 4,
    parameter int PA_WIDTH  = 28,
    parameter int FLG_WIDTH = 4
);
    logic [NUM_REQ-1:0]          req_vld;
    logic [NUM_REQ*PA_WIDTH-1:0] req_pa;
    logic [NUM_REQ-1:0]          req_mprv;
    logic [NUM_REQ-1:0]          req_rdy;
    logic [NUM_REQ-1:0]          rsp_vld;
    logic [FLG_WIDTH-1:0]        rsp_flg;
    logic [PA_WIDTH-1:0]         arb_pmp_pa;
    logic                        arb_pmp_mprv;
    logic [FLG_WIDTH-1:0]        pmp_arb_flg;
    logic                        cp0_pmp_wreg;
    logic                        arb_busy;

    modport slave (
        input  req_vld, req_pa, req_mprv, pmp_arb_flg, cp0_pmp_wreg,
        output req_rdy, rsp_vld, rsp_flg, arb_pmp_pa, arb_pmp_mprv, arb_busy
    );

    modport master (
        output req_vld, req_pa, req_mprv, pmp_arb_flg, cp0_pmp_wreg,
        input  req_rdy, rsp_vld, rsp_flg, arb_pmp_pa, arb_pmp_mprv, arb_busy
    );
endinterface

// File: rtl/ct_pmp_chk_arb.sv
// Round-robin sharing of one ct_pmp_acc lookup port among NUM_REQ PA-check requesters.
// The pipeline has two stages: grant/PA register, then flag capture. A CSR-write blackout keeps responses off a stale config.
module ct_pmp_chk_arb #(
    parameter int NUM_REQ   = 4,
    parameter int PA_WIDTH  = 28,
    parameter int FLG_WIDTH = 4
) (
    input  logic            forever_cpuclk,
    input  logic            cpurst,
    ct_pmp_chk_arb_if.slave pmp_bus
);
    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic {ST_RUN = 1'b0, ST_BLOCK = 1'b1} state_t;

    state_t               r_state, w_state_nxt;
    logic [NUM_REQ-1:0]   r_inflight;
    logic [IDW-1:0]       r_rr_ptr;
    logic [NUM_REQ-1:0]   w_elig, w_gnt_oh, w_s1_clr;
    logic [IDW-1:0]       w_win;
    logic                 w_found, w_gnt, w_promote;

    logic                 r_s1_vld;
    logic [IDW-1:0]       r_s1_id;
    logic [PA_WIDTH-1:0]  r_s1_pa;
    logic                 r_s1_mprv;
    logic                 r_s2_vld;
    logic [IDW-1:0]       r_s2_id;
    logic [FLG_WIDTH-1:0] r_s2_flg;

    // BLOCK lasts exactly as long as the write strobe, delayed by one cycle
    always_comb begin
        w_state_nxt = r_state;
        w_state_nxt = pmp_bus.cp0_pmp_wreg ? ST_BLOCK : ST_RUN;
    end

    assign w_elig = pmp_bus.req_vld & ~r_inflight;

    always_comb begin : rr_pick
        logic [IDW-1:0] w_idx;
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = IDW'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_gnt     = (r_state == ST_RUN) & ~pmp_bus.cp0_pmp_wreg & ~cpurst & w_found;
    assign w_gnt_oh  = w_gnt ? (NUM_REQ'(1) << w_win) : '0;
    // A stage-1 entry frees its requester on leaving, whether it is promoted or squashed
    assign w_s1_clr  = r_s1_vld ? (NUM_REQ'(1) << r_s1_id) : '0;
    assign w_promote = r_s1_vld & ~pmp_bus.cp0_pmp_wreg;

    // Stage 0 -> 1: grant and register PA. Stage 1 -> 2: capture accessor flags.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_state    <= ST_RUN;
            r_s1_vld   <= 1'b0;
            r_s2_vld   <= 1'b0;
            r_inflight <= '0;
            r_rr_ptr   <= IDW'(NUM_REQ - 1);
            r_s1_pa    <= '0;
            r_s1_mprv  <= 1'b0;
            r_s2_flg   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_s1_vld   <= w_gnt;
            r_s2_vld   <= w_promote;
            r_inflight <= (r_inflight & ~w_s1_clr) | w_gnt_oh;
            if (w_gnt) begin
                r_rr_ptr  <= w_win;
                r_s1_pa   <= pmp_bus.req_pa[w_win*PA_WIDTH +: PA_WIDTH];
                r_s1_mprv <= pmp_bus.req_mprv[w_win];
            end
            if (w_promote) begin
                r_s2_flg <= pmp_bus.pmp_arb_flg;
            end
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (w_gnt) begin
            r_s1_id <= w_win;
        end
        if (w_promote) begin
            r_s2_id <= r_s1_id;
        end
    end

    assign pmp_bus.req_rdy      = w_gnt_oh;
    assign pmp_bus.rsp_vld      = r_s2_vld ? (NUM_REQ'(1) << r_s2_id) : '0;
    assign pmp_bus.rsp_flg      = r_s2_flg;
    assign pmp_bus.arb_pmp_pa   = r_s1_pa;
    assign pmp_bus.arb_pmp_mprv = r_s1_mprv;
    assign pmp_bus.arb_busy     = r_s1_vld | r_s2_vld | (r_state == ST_BLOCK);
endmodule

// File: tb/tb_ct_pmp_chk_arb.sv
// Bench for ct_pmp_chk_arb: directed cycle table, reset corner sequence, random traffic vs. transaction model.
module tb_ct_pmp_chk_arb;
    localparam int N  = 4;
    localparam int PW = 28;
    localparam int FW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ct_pmp_chk_arb_if #(.NUM_REQ(N), .PA_WIDTH(PW), .FLG_WIDTH(FW)) bus ();

    ct_pmp_chk_arb #(.NUM_REQ(N), .PA_WIDTH(PW), .FLG_WIDTH(FW)) dut (
        .forever_cpuclk (clk),
        .cpurst         (rst),
        .pmp_bus        (bus.slave)
    );

    // Stand-in for ct_pmp_acc: flags depend on PA, MPRV and the current CSR config
    logic [3:0] cfg = 4'hA;
    function automatic logic [3:0] acc_f(input logic [PW-1:0] pa, input logic m, input logic [3:0] c);
        return pa[3:0] ^ pa[7:4] ^ {m, 3'b000} ^ c;
    endfunction
    assign bus.pmp_arb_flg = acc_f(bus.arb_pmp_pa, bus.arb_pmp_mprv, cfg);
    always @(posedge clk) if (bus.cp0_pmp_wreg) cfg <= cfg + 4'h3;

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @t=%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    logic [PW-1:0] pa_arr [N];
    logic [N-1:0]  mprv_v;

    // Transaction model: each grant responds two cycles later unless a CSR write lands one cycle after it
    typedef struct {
        int            g;
        int            id;
        logic [PW-1:0] pa;
        logic          mprv;
        logic [3:0]    flg;
    } rec_t;
    rec_t          q[$];
    int            t = 0;
    int            m_free [N];
    int            m_last = N - 1;
    bit            m_wprev = 1'b0;
    logic [PW-1:0] m_pa = '0;
    logic          m_mprv = 1'b0;
    logic [3:0]    m_flg = '0;

    task automatic do_cycle(input bit r, input logic [N-1:0] req, input bit wreg);
        logic [N-1:0] e_rdy, e_rsp;
        logic [3:0]   e_flg;
        bit           e_busy, blk;
        int           w;
        rec_t         rr;
        @(negedge clk);
        rst = r;
        bus.req_vld = req;
        bus.cp0_pmp_wreg = wreg;
        bus.req_mprv = mprv_v;
        for (int i = 0; i < N; i++) bus.req_pa[i*PW +: PW] = pa_arr[i];
        #1;
        e_rdy = '0; e_rsp = '0; e_flg = m_flg; e_busy = m_wprev; w = -1;
        foreach (q[k]) begin
            if (q[k].g == t - 1) e_busy = 1'b1;
            if (q[k].g == t - 2) begin
                e_busy = 1'b1;
                e_rsp  = e_rsp | (N'(1) << q[k].id);
                e_flg  = q[k].flg;
            end
        end
        blk = r || wreg || m_wprev;
        if (!blk) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (w < 0 && req[c] && t >= m_free[c]) w = c;
            end
        end
        if (w >= 0) e_rdy = N'(1) << w;
        chk("req_rdy", 32'(bus.req_rdy), 32'(e_rdy));
        if (!r) begin
            chk("rsp_vld", 32'(bus.rsp_vld), 32'(e_rsp));
            chk("rsp_flg", 32'(bus.rsp_flg), 32'(e_flg));
            chk("arb_pmp_pa", 32'(bus.arb_pmp_pa), 32'(m_pa));
            chk("arb_pmp_mprv", 32'(bus.arb_pmp_mprv), 32'(m_mprv));
            chk("arb_busy", 32'(bus.arb_busy), 32'(e_busy));
        end
        if (r) begin
            q.delete();
            foreach (m_free[i]) m_free[i] = 0;
            m_last = N - 1; m_wprev = 1'b0; m_pa = '0; m_mprv = 1'b0; m_flg = '0;
        end else begin
            for (int k = q.size() - 1; k >= 0; k--) begin
                if (q[k].g == t - 2) q.delete(k);
                else if (q[k].g == t - 1) begin
                    if (wreg) q.delete(k);
                    else begin
                        rr = q[k];
                        rr.flg = acc_f(rr.pa, rr.mprv, cfg);
                        q[k] = rr;
                    end
                end
            end
            if (w >= 0) begin
                rr.g = t; rr.id = w; rr.pa = pa_arr[w]; rr.mprv = mprv_v[w]; rr.flg = '0;
                q.push_back(rr);
                m_free[w] = t + 2; m_last = w; m_pa = pa_arr[w]; m_mprv = mprv_v[w];
            end
            m_wprev = wreg;
            m_flg = e_flg;
        end
        t++;
    endtask

    typedef struct {
        logic [N-1:0] req;
        bit           wreg;
        logic [N-1:0] rdy;
        logic [N-1:0] rsp;
        bit           busy;
    } vec_t;
    vec_t tbl [31];

    initial begin
        tbl[0]  = '{4'b0001, 0, 4'b0001, 4'b0000, 0};
        tbl[1]  = '{4'b0001, 0, 4'b0000, 4'b0000, 1};
        tbl[2]  = '{4'b0001, 0, 4'b0001, 4'b0001, 1};
        tbl[3]  = '{4'b0000, 0, 4'b0000, 4'b0000, 1};
        tbl[4]  = '{4'b0000, 0, 4'b0000, 4'b0001, 1};
        tbl[5]  = '{4'b0000, 0, 4'b0000, 4'b0000, 0};
        tbl[6]  = '{4'b0100, 0, 4'b0100, 4'b0000, 0};
        tbl[7]  = '{4'b0100, 1, 4'b0000, 4'b0000, 1};
        tbl[8]  = '{4'b0100, 0, 4'b0000, 4'b0000, 1};
        tbl[9]  = '{4'b0100, 0, 4'b0100, 4'b0000, 0};
        tbl[10] = '{4'b0100, 0, 4'b0000, 4'b0000, 1};
        tbl[11] = '{4'b0100, 0, 4'b0100, 4'b0100, 1};
        tbl[12] = '{4'b0000, 0, 4'b0000, 4'b0000, 1};
        tbl[13] = '{4'b0000, 0, 4'b0000, 4'b0100, 1};
        tbl[14] = '{4'b0000, 0, 4'b0000, 4'b0000, 0};
        tbl[15] = '{4'b1111, 0, 4'b1000, 4'b0000, 0};
        tbl[16] = '{4'b1111, 0, 4'b0001, 4'b0000, 1};
        tbl[17] = '{4'b1111, 0, 4'b0010, 4'b1000, 1};
        tbl[18] = '{4'b1111, 0, 4'b0100, 4'b0001, 1};
        tbl[19] = '{4'b1111, 0, 4'b1000, 4'b0010, 1};
        tbl[20] = '{4'b0000, 0, 4'b0000, 4'b0100, 1};
        tbl[21] = '{4'b0000, 0, 4'b0000, 4'b1000, 1};
        tbl[22] = '{4'b0000, 0, 4'b0000, 4'b0000, 0};
        tbl[23] = '{4'b0001, 1, 4'b0000, 4'b0000, 0};
        tbl[24] = '{4'b0001, 1, 4'b0000, 4'b0000, 1};
        tbl[25] = '{4'b0001, 1, 4'b0000, 4'b0000, 1};
        tbl[26] = '{4'b0001, 0, 4'b0000, 4'b0000, 1};
        tbl[27] = '{4'b0001, 0, 4'b0001, 4'b0000, 0};
        tbl[28] = '{4'b0000, 0, 4'b0000, 4'b0000, 1};
        tbl[29] = '{4'b0000, 0, 4'b0000, 4'b0001, 1};
        tbl[30] = '{4'b0000, 0, 4'b0000, 4'b0000, 0};

        bus.req_vld = '0; bus.req_pa = '0; bus.req_mprv = '0; bus.cp0_pmp_wreg = 1'b0;
        for (int i = 0; i < N; i++) pa_arr[i] = 28'h0001000 + PW'(i) * 28'h110;
        mprv_v = 4'b1000;

        do_cycle(1, '0, 0);
        do_cycle(1, '0, 0);
        do_cycle(0, '0, 0);
        chk("reset rsp_vld", 32'(bus.rsp_vld), 32'h0);
        chk("reset busy", 32'(bus.arb_busy), 32'h0);
        chk("reset pa", 32'(bus.arb_pmp_pa), 32'h0);

        for (int i = 0; i < 31; i++) begin
            do_cycle(0, tbl[i].req, tbl[i].wreg);
            chk($sformatf("tbl%0d rdy", i), 32'(bus.req_rdy), 32'(tbl[i].rdy));
            chk($sformatf("tbl%0d rsp", i), 32'(bus.rsp_vld), 32'(tbl[i].rsp));
            chk($sformatf("tbl%0d busy", i), 32'(bus.arb_busy), 32'(tbl[i].busy));
            if (i == 1) chk("T1 pa", 32'(bus.arb_pmp_pa), 32'h0001000);
            if (i == 2) chk("T1 flg", 32'(bus.rsp_flg), 32'hA);
        end

        // Reset while both pipeline stages hold lookups
        do_cycle(0, 4'b0010, 0);
        do_cycle(0, 4'b0110, 0);
        do_cycle(1, 4'b0110, 0);
        chk("T5 rdy in reset", 32'(bus.req_rdy), 32'h0);
        do_cycle(0, 4'b1111, 0);
        chk("T5 rsp after reset", 32'(bus.rsp_vld), 32'h0);
        chk("T5 busy after reset", 32'(bus.arb_busy), 32'h0);
        chk("T5 first grant", 32'(bus.req_rdy), 32'h1);
        do_cycle(0, 4'b1110, 0);
        do_cycle(0, 4'b0000, 0);
        do_cycle(0, 4'b0000, 0);

        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) pa_arr[i] = PW'($urandom);
            mprv_v = N'($urandom);
            do_cycle(($urandom_range(0, 99) == 0), N'($urandom), ($urandom_range(0, 7) == 0));
        end
        for (int c = 0; c < 4; c++) do_cycle(0, '0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
